// File: rtl/tspp_bus_arbiter.sv
// tspp_bus_arbiter: shares one memory port between fetch (read-only) and data (read/write).
// Data has priority; an aging counter guarantees fetch progress.
module tspp_bus_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [ADDR_W-1:0]   i_addr,
   input  logic                i_ren,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_busy,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic                d_ren,
   input  logic                d_wen,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_byte_en,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_busy,
   output logic [ADDR_W-1:0]   m_addr,
   output logic                m_ren,
   output logic                m_wen,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_byte_en,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_busy,
   output logic [1:0]          owner
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      I_LOCK,
      D_LOCK
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   lat_addr;
   logic                lat_ren;
   logic                lat_wen;
   logic [DATA_W-1:0]   lat_wdata;
   logic [BE_W-1:0]     lat_be;
   logic [CNT_W-1:0]    starve_cnt;

   logic d_req;
   logic starved;
   logic cnt_sat;
   logic d_win;
   logic i_win;

   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;

   always_comb begin
      d_req   = d_ren | d_wen;
      cnt_sat = (starve_cnt == CNT_W'(STARVE_LIMIT));
      starved = (STARVE_LIMIT != 0) && i_ren && cnt_sat;
      d_win   = (state == IDLE) && d_req && !starved;
      i_win   = (state == IDLE) && i_ren && !d_win;
   end

   // Locked states replay the latch; IDLE forwards the live winner.
   always_comb begin
      m_addr    = lat_addr;
      m_ren     = lat_ren;
      m_wen     = lat_wen;
      m_wdata   = lat_wdata;
      m_byte_en = lat_be;
      owner     = 2'b00;
      i_busy    = 1'b1;
      d_busy    = 1'b1;
      unique case (state)
         IDLE: begin
            m_ren = 1'b0;
            m_wen = 1'b0;
            if (d_win) begin
               m_addr    = d_addr;
               m_ren     = d_ren & ~d_wen;
               m_wen     = d_wen;
               m_wdata   = d_wdata;
               m_byte_en = d_byte_en;
               owner     = 2'b10;
               d_busy    = m_busy;
            end else if (i_win) begin
               m_addr    = i_addr;
               m_ren     = 1'b1;
               m_wdata   = '0;
               m_byte_en = '1;
               owner     = 2'b01;
               i_busy    = m_busy;
            end
         end
         I_LOCK: begin
            owner  = 2'b01;
            i_busy = m_busy;
         end
         D_LOCK: begin
            owner  = 2'b10;
            d_busy = m_busy;
         end
         default: ;
      endcase
      if (RST) begin
         m_ren  = 1'b0;
         m_wen  = 1'b0;
         i_busy = 1'b1;
         d_busy = 1'b1;
         owner  = 2'b00;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         starve_cnt <= '0;
         lat_addr   <= '0;
         lat_ren    <= 1'b0;
         lat_wen    <= 1'b0;
         lat_wdata  <= '0;
         lat_be     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (d_win || i_win) begin
                  lat_addr  <= m_addr;
                  lat_ren   <= m_ren;
                  lat_wen   <= m_wen;
                  lat_wdata <= m_wdata;
                  lat_be    <= m_byte_en;
                  if (i_win)
                     starve_cnt <= '0;
                  else if (i_ren && !cnt_sat)
                     starve_cnt <= starve_cnt + 1'b1;
                  if (m_busy)
                     state <= d_win ? D_LOCK : I_LOCK;
               end
            end
            I_LOCK, D_LOCK: begin
               if (!m_busy)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_rw_excl: assert property (
      @(posedge CLK) disable iff (RST) !(d_ren && d_wen)
   );

endmodule
